// File: rtl/param_pattern_generator.sv
// Parameterised video test-pattern source (checker, colour bars, solid, grey ramp)
// streaming one pixel per valid/ready transfer with frame and line markers.
module param_pattern_generator #(
  parameter int          H_ACTIVE = 800,
  parameter int          V_ACTIVE = 600,
  parameter int          TILE_W   = 64,
  parameter int          TILE_H   = 32,
  parameter logic [23:0] COLOR_A  = 24'hFF33FF,
  parameter logic [23:0] COLOR_B  = 24'hFF3333,
  parameter logic [23:0] COLOR_C  = 24'h0065D9,
  parameter logic [23:0] COLOR_D  = 24'h62D900
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        Enable,
  input  logic [1:0]  Mode,
  input  logic [23:0] SolidColor,
  input  logic        VideoReady,
  output logic        VideoValid,
  output logic [23:0] Video,
  output logic        StartOfFrame,
  output logic        EndOfLine,
  output logic [15:0] FrameCount
);

  localparam int XW    = ($clog2(H_ACTIVE) > 8) ? $clog2(H_ACTIVE) : 8;
  localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int TXW   = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int TYW   = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam int BAR_W = H_ACTIVE / 8;

  localparam logic [XW-1:0]  X_LAST   = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0]  Y_LAST   = YW'(V_ACTIVE - 1);
  localparam logic [TXW-1:0] TX_LAST  = TXW'(TILE_W - 1);
  localparam logic [TYW-1:0] TY_LAST  = TYW'(TILE_H - 1);
  localparam logic [XW-1:0]  BAR_LAST = XW'(BAR_W - 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;
  typedef enum logic [1:0] {MODE_CHECKER, MODE_BARS, MODE_SOLID, MODE_RAMP} mode_e;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = 24'hFFFFFF;
      3'd1:    bar_color = 24'hFFFF00;
      3'd2:    bar_color = 24'h00FFFF;
      3'd3:    bar_color = 24'h00FF00;
      3'd4:    bar_color = 24'hFF00FF;
      3'd5:    bar_color = 24'hFF0000;
      3'd6:    bar_color = 24'h0000FF;
      default: bar_color = 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] pixel_color(input mode_e md, input logic [23:0] solid,
                                              input logic [7:0] ramp, input logic trow,
                                              input logic tcol, input logic [2:0] bar);
    case (md)
      MODE_CHECKER: begin
        case ({trow, tcol})
          2'b00:   pixel_color = COLOR_A;
          2'b01:   pixel_color = COLOR_B;
          2'b10:   pixel_color = COLOR_C;
          default: pixel_color = COLOR_D;
        endcase
      end
      MODE_BARS:  pixel_color = bar_color(bar);
      MODE_SOLID: pixel_color = solid;
      default:    pixel_color = {ramp, ramp, ramp};
    endcase
  endfunction

  // Reset asserts immediately but releases two clock edges later, so no flop
  // sees a reset edge racing its clock.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  state_e         state_q, state_d;
  mode_e          mode_q, mode_d;
  logic [23:0]    solid_q, solid_d;
  logic [XW-1:0]  x_q, x_d, bc_q, bc_d;
  logic [YW-1:0]  y_q, y_d;
  logic [TXW-1:0] tx_q, tx_d;
  logic [TYW-1:0] ty_q, ty_d;
  logic           tcol_q, tcol_d, trow_q, trow_d;
  logic [2:0]     bi_q, bi_d;
  logic [15:0]    frame_q, frame_d;
  logic           valid_q, valid_d, sof_q, sof_d, eol_q, eol_d;
  logic [23:0]    video_q, video_d;
  logic           transfer, line_end, frame_end;

  assign transfer  = valid_q && VideoReady;
  assign line_end  = (x_q == X_LAST);
  assign frame_end = line_end && (y_q == Y_LAST);

  always_comb begin
    // NOTE: every next-state signal takes its held value first so no path can infer a latch.
    state_d = state_q;
    mode_d  = mode_q;
    solid_d = solid_q;
    x_d     = x_q;
    y_d     = y_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    tcol_d  = tcol_q;
    trow_d  = trow_q;
    bc_d    = bc_q;
    bi_d    = bi_q;
    frame_d = frame_q;
    valid_d = valid_q;

    case (state_q)
      ST_IDLE: begin
        if (Enable) begin
          state_d = ST_RUN;
          mode_d  = mode_e'(Mode);
          solid_d = SolidColor;
          x_d     = '0;
          y_d     = '0;
          tx_d    = '0;
          ty_d    = '0;
          tcol_d  = 1'b0;
          trow_d  = 1'b0;
          bc_d    = '0;
          bi_d    = 3'd0;
          valid_d = 1'b1;
        end
      end
      default: begin
        if (transfer) begin
          if (line_end) begin
            x_d    = '0;
            tx_d   = '0;
            tcol_d = 1'b0;
            bc_d   = '0;
            bi_d   = 3'd0;
            if (frame_end) begin
              y_d     = '0;
              ty_d    = '0;
              trow_d  = 1'b0;
              frame_d = frame_q + 16'd1;
              mode_d  = mode_e'(Mode);
              solid_d = SolidColor;
              if (!Enable) begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
              end
            end else begin
              y_d = y_q + 1'b1;
              if (ty_q == TY_LAST) begin
                ty_d   = '0;
                trow_d = ~trow_q;
              end else begin
                ty_d = ty_q + 1'b1;
              end
            end
          end else begin
            x_d = x_q + 1'b1;
            if (tx_q == TX_LAST) begin
              tx_d   = '0;
              tcol_d = ~tcol_q;
            end else begin
              tx_d = tx_q + 1'b1;
            end
            // The last bar absorbs the remainder of H_ACTIVE/8.
            if (bi_q != 3'd7) begin
              if (bc_q == BAR_LAST) begin
                bc_d = '0;
                bi_d = bi_q + 3'd1;
              end else begin
                bc_d = bc_q + 1'b1;
              end
            end
          end
        end
      end
    endcase

    if (valid_d) begin
      video_d = pixel_color(mode_d, solid_d, x_d[7:0], trow_d, tcol_d, bi_d);
      sof_d   = (x_d == '0) && (y_d == '0);
      eol_d   = (x_d == X_LAST);
    end else begin
      video_d = 24'h000000;
      sof_d   = 1'b0;
      eol_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_CHECKER;
      solid_q <= 24'h000000;
      x_q     <= '0;
      y_q     <= '0;
      tx_q    <= '0;
      ty_q    <= '0;
      tcol_q  <= 1'b0;
      trow_q  <= 1'b0;
      bc_q    <= '0;
      bi_q    <= 3'd0;
      frame_q <= 16'd0;
      valid_q <= 1'b0;
      video_q <= 24'h000000;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      state_q <= state_d;
      mode_q  <= mode_d;
      solid_q <= solid_d;
      x_q     <= x_d;
      y_q     <= y_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      tcol_q  <= tcol_d;
      trow_q  <= trow_d;
      bc_q    <= bc_d;
      bi_q    <= bi_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      video_q <= video_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
    end
  end

  assign VideoValid   = valid_q;
  assign Video        = video_q;
  assign StartOfFrame = sof_q;
  assign EndOfLine    = eol_q;
  assign FrameCount   = frame_q;

endmodule

// File: tb/tb_param_pattern_generator.sv
// Directed bench for param_pattern_generator; frame height and tile height are
// reduced (non-power-of-two tile height) so several whole frames fit the run.
module tb_param_pattern_generator;

  localparam int H  = 800;
  localparam int V  = 13;
  localparam int TW = 64;
  localparam int TH = 3;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        Enable;
  logic [1:0]  Mode;
  logic [23:0] SolidColor;
  logic        VideoReady;
  logic        VideoValid;
  logic [23:0] Video;
  logic        StartOfFrame;
  logic        EndOfLine;
  logic [15:0] FrameCount;

  int n_cmp    = 0;
  int n_bad    = 0;
  int scan_err = 0;
  int bx, by;
  logic [1:0]  m_mode;
  logic [23:0] m_solid;

  always #5 clock = ~clock;

  param_pattern_generator #(
    .H_ACTIVE(H), .V_ACTIVE(V), .TILE_W(TW), .TILE_H(TH)
  ) dut (
    .clock(clock), .reset_n(reset_n), .Enable(Enable), .Mode(Mode),
    .SolidColor(SolidColor), .VideoReady(VideoReady), .VideoValid(VideoValid),
    .Video(Video), .StartOfFrame(StartOfFrame), .EndOfLine(EndOfLine),
    .FrameCount(FrameCount)
  );

  function automatic logic [23:0] exp_color(input logic [1:0] md, input logic [23:0] sc,
                                            input int x, input int y);
    logic [23:0] c;
    int row, col, bar;
    c = 24'h0;
    if (md == 2'd0) begin
      row = (y / TH) % 2;
      col = (x / TW) % 2;
      if (row == 0) c = (col == 0) ? 24'hFF33FF : 24'hFF3333;
      else          c = (col == 0) ? 24'h0065D9 : 24'h62D900;
    end else if (md == 2'd1) begin
      bar = x / (H / 8);
      if (bar > 7) bar = 7;
      case (bar)
        0: c = 24'hFFFFFF;
        1: c = 24'hFFFF00;
        2: c = 24'h00FFFF;
        3: c = 24'h00FF00;
        4: c = 24'hFF00FF;
        5: c = 24'hFF0000;
        6: c = 24'h0000FF;
        default: c = 24'h000000;
      endcase
    end else if (md == 2'd2) begin
      c = sc;
    end else begin
      c = {x[7:0], x[7:0], x[7:0]};
    end
    return c;
  endfunction

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic adv_model();
    bx++;
    if (bx == H) begin
      bx = 0;
      by++;
      if (by == V) begin
        by      = 0;
        m_mode  = Mode;
        m_solid = SolidColor;
      end
    end
  endtask

  // Streams n pixels with VideoReady high, tallying any pixel that departs from the model.
  task automatic walk(input int n);
    for (int i = 0; i < n; i++) begin
      VideoReady = 1'b1;
      if (VideoValid !== 1'b1 || Video !== exp_color(m_mode, m_solid, bx, by) ||
          StartOfFrame !== (bx == 0 && by == 0) || EndOfLine !== (bx == H - 1))
        scan_err++;
      tick();
      adv_model();
    end
  endtask

  task automatic goto_px(input int x, input int y);
    walk((y * H + x) - (by * H + bx));
  endtask

  task automatic test_reset();
    reset_n = 1'b0; Enable = 1'b0; VideoReady = 1'b1; Mode = 2'd0; SolidColor = 24'h0;
    repeat (3) tick();
    n_cmp++; if (VideoValid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", VideoValid); end
    n_cmp++; if (Video !== 24'h0) begin n_bad++; $display("FAIL rst_video: got %h want 000000", Video); end
    n_cmp++; if (StartOfFrame !== 1'b0) begin n_bad++; $display("FAIL rst_sof: got %b want 0", StartOfFrame); end
    n_cmp++; if (EndOfLine !== 1'b0) begin n_bad++; $display("FAIL rst_eol: got %b want 0", EndOfLine); end
    n_cmp++; if (FrameCount !== 16'd0) begin n_bad++; $display("FAIL rst_fc: got %0d want 0", FrameCount); end
    reset_n = 1'b1; Enable = 1'b1;
    tick();
    n_cmp++; if (VideoValid !== 1'b0) begin n_bad++; $display("FAIL rst_sync_edge1: got %b want 0", VideoValid); end
    for (int i = 0; i < 8 && VideoValid !== 1'b1; i++) tick();
    n_cmp++; if (VideoValid !== 1'b1) begin n_bad++; $display("FAIL start_timeout: valid %b want 1", VideoValid); end
    bx = 0; by = 0; m_mode = 2'd0; m_solid = 24'h0;
    n_cmp++; if (StartOfFrame !== 1'b1) begin n_bad++; $display("FAIL first_sof: got %b want 1", StartOfFrame); end
    n_cmp++; if (Video !== 24'hFF33FF) begin n_bad++; $display("FAIL px_0_0: got %h want FF33FF", Video); end
  endtask

  task automatic test_checker();
    scan_err = 0;
    goto_px(64, 0);
    n_cmp++; if (Video !== 24'hFF3333) begin n_bad++; $display("FAIL px_64_0: got %h want FF3333", Video); end
    goto_px(0, TH);
    n_cmp++; if (Video !== 24'h0065D9) begin n_bad++; $display("FAIL px_0_th: got %h want 0065D9", Video); end
    goto_px(64, TH);
    n_cmp++; if (Video !== 24'h62D900) begin n_bad++; $display("FAIL px_64_th: got %h want 62D900", Video); end
    goto_px(0, 6);
    n_cmp++; if (scan_err !== 0) begin n_bad++; $display("FAIL checker_scan: %0d bad pixels want 0", scan_err); end
  endtask

  task automatic test_mode_change();
    scan_err = 0;
    Mode = 2'd2; SolidColor = 24'h123456;
    goto_px(H - 1, V - 1);
    n_cmp++; if (Video !== 24'hFF33FF) begin n_bad++; $display("FAIL px_last: got %h want FF33FF", Video); end
    n_cmp++; if (EndOfLine !== 1'b1) begin n_bad++; $display("FAIL eol_last: got %b want 1", EndOfLine); end
    n_cmp++; if (FrameCount !== 16'd0) begin n_bad++; $display("FAIL fc_before: got %0d want 0", FrameCount); end
    walk(1);
    n_cmp++; if (FrameCount !== 16'd1) begin n_bad++; $display("FAIL fc_after: got %0d want 1", FrameCount); end
    n_cmp++; if (Video !== 24'h123456) begin n_bad++; $display("FAIL solid_first: got %h want 123456", Video); end
    n_cmp++; if (StartOfFrame !== 1'b1) begin n_bad++; $display("FAIL solid_sof: got %b want 1", StartOfFrame); end
    goto_px(400, 6);
    n_cmp++; if (Video !== 24'h123456) begin n_bad++; $display("FAIL solid_mid: got %h want 123456", Video); end
    Mode = 2'd3;
    goto_px(H - 1, V - 1);
    n_cmp++; if (FrameCount !== 16'd1) begin n_bad++; $display("FAIL fc_once: got %0d want 1", FrameCount); end
    walk(1);
    n_cmp++; if (VideoValid !== 1'b1 || Video !== 24'h000000) begin
      n_bad++; $display("FAIL ramp_first: valid %b video %h want 1 000000", VideoValid, Video); end
    n_cmp++; if (scan_err !== 0) begin n_bad++; $display("FAIL mode_scan: %0d bad pixels want 0", scan_err); end
  endtask

  task automatic test_backpressure();
    scan_err = 0;
    goto_px(10, 0);
    n_cmp++; if (Video !== 24'h0A0A0A) begin n_bad++; $display("FAIL bp_x10: got %h want 0A0A0A", Video); end
    VideoReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (Video !== 24'h0A0A0A || VideoValid !== 1'b1 || EndOfLine !== 1'b0 || StartOfFrame !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold%0d: video %h valid %b eol %b sof %b want 0A0A0A 1 0 0",
                          i, Video, VideoValid, EndOfLine, StartOfFrame); end
    end
    VideoReady = 1'b1;
    tick();
    adv_model();
    n_cmp++; if (Video !== 24'h0B0B0B) begin n_bad++; $display("FAIL bp_x11: got %h want 0B0B0B", Video); end
    goto_px(256, 0);
    n_cmp++; if (Video !== 24'h000000) begin n_bad++; $display("FAIL ramp_wrap: got %h want 000000", Video); end
    goto_px(300, 5);
    n_cmp++; if (Video !== 24'h2C2C2C) begin n_bad++; $display("FAIL ramp_x300: got %h want 2C2C2C", Video); end
    Mode = 2'd1;
    goto_px(H - 1, V - 1);
    walk(1);
    n_cmp++; if (scan_err !== 0) begin n_bad++; $display("FAIL ramp_scan: %0d bad pixels want 0", scan_err); end
  endtask

  task automatic test_colour_bars();
    scan_err = 0;
    n_cmp++; if (Video !== 24'hFFFFFF) begin n_bad++; $display("FAIL bar_x0: got %h want FFFFFF", Video); end
    goto_px(100, 0);
    n_cmp++; if (Video !== 24'hFFFF00) begin n_bad++; $display("FAIL bar_x100: got %h want FFFF00", Video); end
    goto_px(699, 0);
    n_cmp++; if (Video !== 24'h0000FF) begin n_bad++; $display("FAIL bar_x699: got %h want 0000FF", Video); end
    goto_px(798, 0);
    n_cmp++; if (EndOfLine !== 1'b0) begin n_bad++; $display("FAIL eol_x798: got %b want 0", EndOfLine); end
    goto_px(799, 0);
    n_cmp++; if (Video !== 24'h000000 || EndOfLine !== 1'b1) begin
      n_bad++; $display("FAIL bar_x799: video %h eol %b want 000000 1", Video, EndOfLine); end
    walk(1);
    n_cmp++; if (Video !== 24'hFFFFFF || EndOfLine !== 1'b0) begin
      n_bad++; $display("FAIL bar_line1: video %h eol %b want FFFFFF 0", Video, EndOfLine); end
    n_cmp++; if (scan_err !== 0) begin n_bad++; $display("FAIL bar_scan: %0d bad pixels want 0", scan_err); end
  endtask

  task automatic test_enable_drop();
    scan_err = 0;
    goto_px(0, 6);
    Enable = 1'b0;
    goto_px(H - 1, V - 1);
    n_cmp++; if (VideoValid !== 1'b1 || FrameCount !== 16'd3) begin
      n_bad++; $display("FAIL drop_last: valid %b fc %0d want 1 3", VideoValid, FrameCount); end
    walk(1);
    n_cmp++; if (scan_err !== 0) begin n_bad++; $display("FAIL drop_scan: %0d bad pixels want 0", scan_err); end
    n_cmp++; if (VideoValid !== 1'b0 || Video !== 24'h0 || StartOfFrame !== 1'b0) begin
      n_bad++; $display("FAIL drop_idle: valid %b video %h sof %b want 0 000000 0", VideoValid, Video, StartOfFrame); end
    n_cmp++; if (FrameCount !== 16'd4) begin n_bad++; $display("FAIL drop_fc: got %0d want 4", FrameCount); end
    repeat (3) tick();
    n_cmp++; if (VideoValid !== 1'b0) begin n_bad++; $display("FAIL drop_stay: got %b want 0", VideoValid); end
  endtask

  task automatic test_async_reset();
    Mode = 2'd0; Enable = 1'b1;
    for (int i = 0; i < 4 && VideoValid !== 1'b1; i++) tick();
    n_cmp++; if (VideoValid !== 1'b1 || StartOfFrame !== 1'b1) begin
      n_bad++; $display("FAIL restart: valid %b sof %b want 1 1", VideoValid, StartOfFrame); end
    bx = 0; by = 0; m_mode = 2'd0; m_solid = SolidColor;
    goto_px(400, 6);
    n_cmp++; if (Video !== 24'hFF33FF || FrameCount !== 16'd4) begin
      n_bad++; $display("FAIL pre_reset: video %h fc %0d want FF33FF 4", Video, FrameCount); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (VideoValid !== 1'b0 || FrameCount !== 16'd0 || Video !== 24'h0) begin
      n_bad++; $display("FAIL async_rst: valid %b fc %0d video %h want 0 0 000000", VideoValid, FrameCount, Video); end
    @(negedge clock);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10 && VideoValid !== 1'b1; i++) tick();
    n_cmp++; if (VideoValid !== 1'b1 || StartOfFrame !== 1'b1 || EndOfLine !== 1'b0) begin
      n_bad++; $display("FAIL post_rst: valid %b sof %b eol %b want 1 1 0", VideoValid, StartOfFrame, EndOfLine); end
    n_cmp++; if (Video !== 24'hFF33FF || FrameCount !== 16'd0) begin
      n_bad++; $display("FAIL post_rst_px: video %h fc %0d want FF33FF 0", Video, FrameCount); end
  endtask

  initial begin
    test_reset();
    test_checker();
    test_mode_change();
    test_backpressure();
    test_colour_bars();
    test_enable_drop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
